// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: FSM state encoding,
// line geometry helpers and the line-slot select macro.

`ifndef CACHE_LINE_SLOT
`define CACHE_LINE_SLOT(k, w) ((k) * (w)) +: (w)
`endif

package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } refill_state_e;

    localparam int INDEX_W = 6;

    function automatic int off_w(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int tag_w(input int addr_width, input int block_size);
        return addr_width - off_w(block_size) - INDEX_W;
    endfunction

endpackage

// File: rtl/cache_refill_watchdog.sv
// Per-beat ack watchdog for the refill engine. Counts REQ cycles without
// an ack and flags expiry once the count reaches TIMEOUT_CYCLES-1.
// Instantiated only when CACHE_REFILL_TIMEOUT_EN is defined.

module cache_refill_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic pon_rst_n_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear on accept/ack, otherwise count waiting REQ cycles, holding at the limit.
    always_ff @(posedge clk) begin
        if (!pon_rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != TERM)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/cache_refill_engine.sv
// Miss line-fill engine: accepts one miss, reads BLOCK_SIZE words over a
// req/ack bus and presents the assembled line with index/tag.
// Optional ack watchdog enabled by defining CACHE_REFILL_TIMEOUT_EN.

module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                        clk,
    input  logic                                        pon_rst_n_i,
    input  logic                                        miss_valid,
    input  logic [ADDR_WIDTH-1:0]                       miss_addr,
    output logic                                        miss_ready,
    output logic                                        mem_req,
    output logic [ADDR_WIDTH-1:0]                       mem_addr,
    input  logic                                        mem_ack,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata,
    output logic                                        fill_valid,
    output logic [INDEX_W-1:0]                          fill_index,
    output logic [tag_w(ADDR_WIDTH, BLOCK_SIZE)-1:0]    fill_tag,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0]            fill_data,
    output logic                                        fill_error,
    output logic                                        busy
);

    localparam int OFF_W  = off_w(BLOCK_SIZE);
    localparam int LADR_W = ADDR_WIDTH - OFF_W;
    localparam int LINE_W = DATA_WIDTH * BLOCK_SIZE;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_SIZE - 1);

    refill_state_e     state_q;
    logic [LADR_W-1:0] line_addr_q;
    logic [OFF_W-1:0]  beat_q;
    logic [OFF_W-1:0]  beat_nxt;
    logic [LINE_W-1:0] line_q;
    logic              mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic              fill_valid_q;
    logic              fill_error_q;
    logic              accept;

    assign accept   = miss_valid && (state_q == ST_IDLE);
    assign beat_nxt = beat_q + OFF_W'(1);

`ifdef CACHE_REFILL_TIMEOUT_EN
    logic wd_expired;

    cache_refill_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .pon_rst_n_i (pon_rst_n_i),
        .clear_i     (accept || ((state_q == ST_REQ) && mem_ack)),
        .run_i       ((state_q == ST_REQ) && !mem_ack),
        .expired_o   (wd_expired)
    );
`endif

    // Refill sequencer with registered bus and fill outputs.
    always_ff @(posedge clk) begin
        if (!pon_rst_n_i) begin
            state_q      <= ST_IDLE;
            line_addr_q  <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_error_q <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            fill_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        line_addr_q <= miss_addr[ADDR_WIDTH-1:OFF_W];
                        mem_addr_q  <= {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        beat_q      <= '0;
                        line_q      <= '0;
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        line_q[`CACHE_LINE_SLOT(beat_q, DATA_WIDTH)] <= mem_rdata;
                        beat_q <= beat_nxt;
                        if (beat_q == LAST_BEAT) begin
                            mem_req_q <= 1'b0;
                            state_q   <= ST_DONE;
                        end else begin
                            // Only the offset field advances; the line address is fixed.
                            mem_addr_q <= {line_addr_q, beat_nxt};
                        end
                    end
`ifdef CACHE_REFILL_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_ERR;
                    end
`endif
                end
                ST_DONE: begin
                    fill_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                ST_ERR: begin
                    fill_valid_q <= 1'b1;
                    fill_error_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miss_ready = (state_q == ST_IDLE);
    assign busy       = ~miss_ready;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign fill_valid = fill_valid_q;
    assign fill_error = fill_error_q;
    assign fill_index = line_addr_q[INDEX_W-1:0];
    assign fill_tag   = line_addr_q[LADR_W-1:INDEX_W];
    assign fill_data  = line_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed self-checking bench for cache_refill_engine (default parameters).

module tb_cache_refill_engine;

    logic         clk = 1'b0;
    logic         pon_rst_n_i = 1'b0;
    logic         miss_valid = 1'b0;
    logic [11:0]  miss_addr = '0;
    logic         miss_ready;
    logic         mem_req;
    logic [11:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         fill_valid;
    logic [5:0]   fill_index;
    logic [3:0]   fill_tag;
    logic [127:0] fill_data;
    logic         fill_error;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;

    cache_refill_engine dut (
        .clk         (clk),
        .pon_rst_n_i (pon_rst_n_i),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .miss_ready  (miss_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .fill_valid  (fill_valid),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .fill_error  (fill_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [11:0] a);
        return {16'hCAFE, 4'h0, a};
    endfunction

    // Present a miss for one edge; cyc restarts at the accept edge.
    task automatic accept(input logic [11:0] a, output int cyc);
        miss_valid = 1'b1;
        miss_addr  = a;
        step();
        miss_valid = 1'b0;
        cyc = 0;
        chk("accept_busy", {127'd0, busy}, 128'd1);
    endtask

    // Serve nbeats beats starting at base, with the given ack gap before each.
    task automatic serve(input logic [11:0] base, input int g0, input int g1,
                         input int g2, input int g3, input int nbeats, inout int cyc);
        int   gaps [4];
        logic dropped;
        logic addr_bad;
        gaps = '{g0, g1, g2, g3};
        dropped  = 1'b0;
        addr_bad = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                mem_ack = 1'b0;
                if (!mem_req) dropped = 1'b1;
                step();
                cyc++;
            end
            if (!mem_req) dropped = 1'b1;
            if (mem_addr !== base + 12'(k)) begin
                addr_bad = 1'b1;
                $display("FAIL beat_addr: got 0x%0h expected 0x%0h", mem_addr, base + 12'(k));
            end
            mem_ack   = 1'b1;
            mem_rdata = word(base + 12'(k));
            step();
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
        chk("req_held", {127'd0, dropped}, 128'd0);
        chk("beat_addrs", {127'd0, addr_bad}, 128'd0);
    endtask

    // Poll for fill_valid with a bounded budget.
    task automatic wait_fill(inout int cyc);
        int budget;
        budget = 0;
        while (!fill_valid && budget < 200) begin
            step();
            cyc++;
            budget++;
        end
        chk("fill_seen", {127'd0, fill_valid}, 128'd1);
    endtask

    int  cyc;
    logic seen;

    initial begin
        // 1. reset values
        step();
        step();
        chk("rst_ready", {127'd0, miss_ready}, 128'd1);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_req", {127'd0, mem_req}, 128'd0);
        chk("rst_addr", {116'd0, mem_addr}, 128'd0);
        chk("rst_fill", {126'd0, fill_valid, fill_error}, 128'd0);
        chk("rst_line", {fill_index, fill_tag, fill_data[117:0]}, 128'd0);
        pon_rst_n_i = 1'b1;
        step();

        // 2. zero-wait refill of 0x2B7
        accept(12'h2B7, cyc);
        chk("t2_first_addr", {116'd0, mem_addr}, 128'h2B4);
        serve(12'h2B4, 0, 0, 0, 0, 4, cyc);
        chk("t2_req_low", {127'd0, mem_req}, 128'd0);
        wait_fill(cyc);
        chk("t2_latency", 128'(cyc), 128'd5);
        chk("t2_error", {127'd0, fill_error}, 128'd0);
        chk("t2_index", {122'd0, fill_index}, 128'h2D);
        chk("t2_tag", {124'd0, fill_tag}, 128'h2);
        chk("t2_data", fill_data, 128'hCAFE02B7_CAFE02B6_CAFE02B5_CAFE02B4);
        step();
        chk("t2_pulse", {127'd0, fill_valid}, 128'd0);
        chk("t2_hold", fill_data, 128'hCAFE02B7_CAFE02B6_CAFE02B5_CAFE02B4);

        // 1b. reset low without an edge, and a stray ack in IDLE
        pon_rst_n_i = 1'b0;
        #3;
        chk("rst_noedge_data", fill_data, 128'hCAFE02B7_CAFE02B6_CAFE02B5_CAFE02B4);
        chk("rst_noedge_ready", {127'd0, miss_ready}, 128'd1);
        #1;
        pon_rst_n_i = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        step();
        chk("idle_ack_ignored", fill_data, 128'hCAFE02B7_CAFE02B6_CAFE02B5_CAFE02B4);
        chk("idle_ack_ready", {127'd0, miss_ready}, 128'd1);

        // 3. ack gaps 3,0,5,2
        accept(12'h2B7, cyc);
        serve(12'h2B4, 3, 0, 5, 2, 4, cyc);
        wait_fill(cyc);
        chk("t3_latency", 128'(cyc), 128'd15);
        chk("t3_data", fill_data, 128'hCAFE02B7_CAFE02B6_CAFE02B5_CAFE02B4);
        step();

        // 4. miss during refill is ignored, then taken in the next IDLE cycle
        accept(12'h2B7, cyc);
        miss_valid = 1'b1;
        miss_addr  = 12'h100;
        serve(12'h2B4, 0, 1, 0, 0, 4, cyc);
        chk("t4_ready_busy", {127'd0, miss_ready}, 128'd0);
        wait_fill(cyc);
        chk("t4_idx_first", {122'd0, fill_index}, 128'h2D);
        chk("t4_ready_fill", {127'd0, miss_ready}, 128'd1);
        step();
        miss_valid = 1'b0;
        cyc = 0;
        chk("t4_second_busy", {127'd0, busy}, 128'd1);
        chk("t4_second_addr", {116'd0, mem_addr}, 128'h100);
        serve(12'h100, 0, 0, 0, 0, 4, cyc);
        wait_fill(cyc);
        chk("t4_tag", {124'd0, fill_tag}, 128'h1);
        chk("t4_index", {122'd0, fill_index}, 128'h0);
        chk("t4_data", fill_data, 128'hCAFE0103_CAFE0102_CAFE0101_CAFE0100);
        step();

        // 5. reset after the 2nd beat
        accept(12'h2B7, cyc);
        serve(12'h2B4, 0, 0, 0, 0, 2, cyc);
        pon_rst_n_i = 1'b0;
        step();
        chk("t5_req", {127'd0, mem_req}, 128'd0);
        chk("t5_busy", {127'd0, busy}, 128'd0);
        chk("t5_data", fill_data, 128'd0);
        pon_rst_n_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (fill_valid) seen = 1'b1;
            step();
        end
        chk("t5_no_fill", {127'd0, seen}, 128'd0);
        accept(12'h040, cyc);
        serve(12'h040, 0, 0, 0, 0, 4, cyc);
        wait_fill(cyc);
        chk("t5_latency", 128'(cyc), 128'd5);
        chk("t5_index", {122'd0, fill_index}, 128'h10);
        chk("t5_tag", {124'd0, fill_tag}, 128'h0);
        chk("t5_new_data", fill_data, 128'hCAFE0043_CAFE0042_CAFE0041_CAFE0040);
        step();

`ifdef CACHE_REFILL_TIMEOUT_EN
        // 6. watchdog abort after beat 0
        accept(12'h3C8, cyc);
        serve(12'h3C8, 0, 0, 0, 0, 1, cyc);
        wait_fill(cyc);
        chk("t6_error", {127'd0, fill_error}, 128'd1);
        chk("t6_req", {127'd0, mem_req}, 128'd0);
        chk("t6_data", fill_data, {96'd0, 32'hCAFE03C8});
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
